// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters with registered response slots.
// Optional build macro ALU_ARB_STATS_EN adds saturating grant/conflict counters.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_op,
  output logic             req0_ready,
  output logic             resp0_valid,
  output logic [WIDTH-1:0] resp0_result,
  input  logic             resp0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_op,
  output logic             req1_ready,
  output logic             resp1_valid,
  output logic [WIDTH-1:0] resp1_result,
  input  logic             resp1_ready,
`ifdef ALU_ARB_STATS_EN
  output logic [15:0]      grant_cnt0,
  output logic [15:0]      grant_cnt1,
  output logic [15:0]      conflict_cnt,
`endif
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_cont,
  input  logic [WIDTH-1:0] alu_result
);

  logic             elig0_s;
  logic             elig1_s;
  logic             grant0_s;
  logic             grant1_s;
  logic             last_grant_r;
  logic             resp0_valid_r;
  logic             resp1_valid_r;
  logic [WIDTH-1:0] resp0_result_r;
  logic [WIDTH-1:0] resp1_result_r;

  // Eligibility and round-robin grant; a draining slot may accept a new request.
  always_comb begin
    elig0_s  = 1'b0;
    elig1_s  = 1'b0;
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (!reset) begin
      elig0_s = req0_valid && (!resp0_valid_r || resp0_ready);
      elig1_s = req1_valid && (!resp1_valid_r || resp1_ready);
    end else begin
      elig0_s = 1'b0;
      elig1_s = 1'b0;
    end
    case ({elig1_s, elig0_s})
      2'b01: grant0_s = 1'b1;
      2'b10: grant1_s = 1'b1;
      2'b11: begin
        if (last_grant_r) begin
          grant0_s = 1'b1;
        end else begin
          grant1_s = 1'b1;
        end
      end
      default: begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
      end
    endcase
  end

  // ALU operand mux: the granted requester drives the ALU, otherwise all zero.
  always_comb begin
    alu_a    = {WIDTH{1'b0}};
    alu_b    = {WIDTH{1'b0}};
    alu_cont = 3'b000;
    if (grant0_s) begin
      alu_a    = req0_a;
      alu_b    = req0_b;
      alu_cont = req0_op;
    end else if (grant1_s) begin
      alu_a    = req1_a;
      alu_b    = req1_b;
      alu_cont = req1_op;
    end else begin
      alu_a    = {WIDTH{1'b0}};
      alu_b    = {WIDTH{1'b0}};
      alu_cont = 3'b000;
    end
  end

  assign req0_ready   = grant0_s;
  assign req1_ready   = grant1_s;
  assign resp0_valid  = resp0_valid_r;
  assign resp1_valid  = resp1_valid_r;
  assign resp0_result = resp0_result_r;
  assign resp1_result = resp1_result_r;

  // Round-robin pointer; reset value 1 lets requester 0 win the first conflict.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_r <= 1'b1;
    end else if (grant0_s) begin
      last_grant_r <= 1'b0;
    end else if (grant1_s) begin
      last_grant_r <= 1'b1;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

  // Response slot 0: a new grant overrides a same-cycle drain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp0_valid_r  <= 1'b0;
      resp0_result_r <= {WIDTH{1'b0}};
    end else if (grant0_s) begin
      resp0_valid_r  <= 1'b1;
      resp0_result_r <= alu_result;
    end else if (resp0_ready) begin
      resp0_valid_r  <= 1'b0;
    end else begin
      resp0_valid_r  <= resp0_valid_r;
    end
  end

  // Response slot 1: same policy as slot 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp1_valid_r  <= 1'b0;
      resp1_result_r <= {WIDTH{1'b0}};
    end else if (grant1_s) begin
      resp1_valid_r  <= 1'b1;
      resp1_result_r <= alu_result;
    end else if (resp1_ready) begin
      resp1_valid_r  <= 1'b0;
    end else begin
      resp1_valid_r  <= resp1_valid_r;
    end
  end

`ifdef ALU_ARB_STATS_EN
  logic [15:0] grant_cnt0_r;
  logic [15:0] grant_cnt1_r;
  logic [15:0] conflict_cnt_r;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      return v;
    end else begin
      return v + 16'd1;
    end
  endfunction

  // Saturating statistics counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_cnt0_r   <= 16'd0;
      grant_cnt1_r   <= 16'd0;
      conflict_cnt_r <= 16'd0;
    end else begin
      if (grant0_s) begin
        grant_cnt0_r <= sat_inc(grant_cnt0_r);
      end else begin
        grant_cnt0_r <= grant_cnt0_r;
      end
      if (grant1_s) begin
        grant_cnt1_r <= sat_inc(grant_cnt1_r);
      end else begin
        grant_cnt1_r <= grant_cnt1_r;
      end
      if (elig0_s && elig1_s) begin
        conflict_cnt_r <= sat_inc(conflict_cnt_r);
      end else begin
        conflict_cnt_r <= conflict_cnt_r;
      end
    end
  end

  assign grant_cnt0   = grant_cnt0_r;
  assign grant_cnt1   = grant_cnt1_r;
  assign conflict_cnt = conflict_cnt_r;
`endif

endmodule
